// File: rtl/vluint_decoder_if.sv
// Request/result handshake and RAM read port of the variable-length integer decoder.
// slave is the decoder's view; master is the requester plus RAM side.
interface vluint_decoder_if #(
  parameter int ADDR_W = 16,
  parameter int OUT_W  = 32
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              signed_mode;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  data;
  logic [ADDR_W-1:0] addr_out;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;

  modport slave (
    input  start, addr, signed_mode, mem_rdata,
    output busy, done, data, addr_out, err, mem_addr, mem_rd
  );

  modport master (
    output start, addr, signed_mode, mem_rdata,
    input  busy, done, data, addr_out, err, mem_addr, mem_rd
  );
endinterface

// File: rtl/vluint_decoder.sv
// LEB128-style decoder: fetches 7-bit groups from a synchronous RAM, 2 cycles per byte,
// with optional sign extension and overflow/over-length reporting.
module vluint_decoder #(
  parameter int ADDR_W    = 16,
  parameter int OUT_W     = 32,
  parameter int MAX_BYTES = (OUT_W + 6) / 7
) (
  input  logic            clk,
  input  logic            reset,
  vluint_decoder_if.slave bus
);
  localparam int KW     = $clog2(MAX_BYTES + 1);
  // Wide enough that every payload bit of every accepted byte has a position, plus one
  // so the dropped-bit slice above OUT_W is never empty.
  localparam int WIDE_W = ((7 * MAX_BYTES > OUT_W) ? 7 * MAX_BYTES : OUT_W) + 1;
  localparam int HI_W   = WIDE_W - OUT_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic              sign_q;
  logic [OUT_W-1:0]  acc;
  logic [KW-1:0]     k;
  logic              drop_one;
  logic              drop_zero;
  logic [OUT_W-1:0]  data_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic              err_q;

  int                shamt;
  logic [WIDE_W-1:0] byte_wide;
  logic [HI_W-1:0]   drop_bits;
  logic [HI_W-1:0]   drop_mask;
  logic              any_one;
  logic              any_zero;
  logic              over_len;
  logic              last_byte;
  logic [OUT_W-1:0]  val_nxt;
  logic              err_nxt;

  function automatic logic [OUT_W-1:0] sign_ext_mask(input int nbits);
    logic [OUT_W-1:0] m;
    for (int i = 0; i < OUT_W; i++) m[i] = (i >= nbits);
    return m;
  endfunction

  // Signed results tolerate dropped bits only if they all replicate the final sign bit.
  function automatic logic overflow_err(input logic sm, input logic msb,
                                        input logic ones, input logic zeros);
    return (sm && msb) ? zeros : ones;
  endfunction

  // WAIT datapath: place the returned byte at bit 7k and classify what falls off the top
  always_comb begin
    shamt     = 7 * int'(k);
    byte_wide = WIDE_W'(bus.mem_rdata[6:0]) << shamt;
    drop_bits = HI_W'(byte_wide >> OUT_W);
    drop_mask = HI_W'((WIDE_W'(7'h7f) << shamt) >> OUT_W);
    any_one   = drop_one | (|drop_bits);
    any_zero  = drop_zero | (|(drop_mask & ~drop_bits));
    over_len  = bus.mem_rdata[7] && (int'(k) + 1 == MAX_BYTES);
    last_byte = !bus.mem_rdata[7] || over_len;
    val_nxt   = acc | byte_wide[OUT_W-1:0];
    if (sign_q && bus.mem_rdata[6]) val_nxt = val_nxt | sign_ext_mask(shamt + 7);
    err_nxt   = over_len | overflow_err(sign_q, val_nxt[OUT_W-1], any_one, any_zero);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.mem_rd = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_FETCH;
      S_FETCH: begin
        bus.mem_rd = 1'b1;
        bus.busy   = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        bus.busy  = 1'b1;
        state_nxt = last_byte ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address pointer and result registers; results change only when a decode completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr   <= '0;
      data_q     <= '0;
      addr_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) cur_addr <= bus.addr;
      if (state == S_WAIT) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        if (last_byte) begin
          data_q     <= val_nxt;
          addr_out_q <= cur_addr + ADDR_W'(1);
          err_q      <= err_nxt;
        end
      end
    end
  end

  // Accumulator state is cleared on every accepted start, so it needs no reset
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.start) begin
      sign_q    <= bus.signed_mode;
      acc       <= '0;
      k         <= '0;
      drop_one  <= 1'b0;
      drop_zero <= 1'b0;
    end else if (state == S_WAIT) begin
      acc       <= acc | byte_wide[OUT_W-1:0];
      k         <= k + KW'(1);
      drop_one  <= any_one;
      drop_zero <= any_zero;
    end
  end

  assign bus.mem_addr = cur_addr;
  assign bus.data     = data_q;
  assign bus.addr_out = addr_out_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_vluint_decoder.sv
// Bench for vluint_decoder: directed vectors, randomized encodings against an arithmetic
// reference model, handshake corner cases and reset mid-decode.
module tb_vluint_decoder;
  localparam int ADDR_W = 16;
  localparam int OUT_W  = 32;

  typedef struct {
    logic [15:0] a;
    int          len;
    logic [39:0] bytes;
    bit          sm;
    logic [31:0] d;
    logic [15:0] ao;
    bit          e;
    int          n;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vluint_decoder_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus();

  vluint_decoder #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .MAX_BYTES(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [0:65535];
  int rd_count = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      rd_count      <= rd_count + 1;
    end
  end

  task automatic load(input logic [15:0] a, input int len, input logic [39:0] bytes);
    for (int i = 0; i < len; i++) mem[16'(a + i)] = bytes[8*i +: 8];
  endtask

  // Reference: sum payload groups as a plain integer, then truncate / extend / judge overflow
  task automatic model(input logic [15:0] a, input bit sm, output logic [31:0] v,
                       output logic [15:0] ao, output bit e, output int n);
    logic [63:0] big;
    logic [63:0] dropped;
    logic [7:0]  b;
    int          dw;
    big = 64'd0; e = 1'b0; n = 0; b = 8'd0;
    for (int i = 0; i < 5; i++) begin
      b   = mem[16'(a + i)];
      big = big + (64'(b[6:0]) << (7 * i));
      n   = i + 1;
      if (!b[7]) break;
    end
    if (b[7]) e = 1'b1;
    v = big[31:0];
    if (sm && b[6] && 7 * n < 32) v = v | (32'hFFFF_FFFF << (7 * n));
    dw = 7 * n - 32;
    if (dw > 0) begin
      dropped = big >> 32;
      if (sm && v[31]) e = e | (dropped != ((64'd1 << dw) - 64'd1));
      else             e = e | (dropped != 64'd0);
    end
    ao = a + 16'(n);
  endtask

  task automatic run_decode(input logic [15:0] a, input bit sm, output logic [31:0] d,
                            output logic [15:0] ao, output bit e, output int lat,
                            output int rds);
    int base;
    @(negedge clk);
    if (bus.done) @(negedge clk);
    bus.start = 1'b1; bus.addr = a; bus.signed_mode = sm;
    base = rd_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL timeout: done not seen after %0d cycles (addr %h)", lat, a);
    end
    d = bus.data; ao = bus.addr_out; e = bus.err; rds = rd_count - base;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.addr = '0; bus.signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
    n_checks++; if (bus.data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data); end
    n_checks++; if (bus.addr_out !== 16'd0) begin n_fail++; $display("FAIL reset_addr_out: got %h want 0", bus.addr_out); end
    n_checks++; if (bus.mem_addr !== 16'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    vec_t        v [11];
    logic [31:0] d;
    logic [15:0] ao;
    bit          e;
    int          lat, rds;
    v[0]  = '{16'h0010, 1, 40'h05,         1'b0, 32'h0000_0005, 16'h0011, 1'b0, 1};
    v[1]  = '{16'h0100, 3, 40'h268EE5,     1'b0, 32'h0009_8765, 16'h0103, 1'b0, 3};
    v[2]  = '{16'h0200, 1, 40'h7F,         1'b1, 32'hFFFF_FFFF, 16'h0201, 1'b0, 1};
    v[3]  = '{16'h0300, 3, 40'h78BBC0,     1'b1, 32'hFFFE_1DC0, 16'h0303, 1'b0, 3};
    v[4]  = '{16'h0300, 3, 40'h78BBC0,     1'b0, 32'h001E_1DC0, 16'h0303, 1'b0, 3};
    v[5]  = '{16'h0400, 5, 40'h0FFFFFFFFF, 1'b0, 32'hFFFF_FFFF, 16'h0405, 1'b0, 5};
    v[6]  = '{16'h0500, 5, 40'h1FFFFFFFFF, 1'b0, 32'hFFFF_FFFF, 16'h0505, 1'b1, 5};
    v[7]  = '{16'h0600, 5, 40'hFFFFFFFFFF, 1'b0, 32'hFFFF_FFFF, 16'h0605, 1'b1, 5};
    v[8]  = '{16'hFFFF, 2, 40'h0181,       1'b0, 32'h0000_0081, 16'h0001, 1'b0, 2};
    v[9]  = '{16'h0700, 5, 40'h0FFFFFFFFF, 1'b1, 32'hFFFF_FFFF, 16'h0705, 1'b1, 5};
    v[10] = '{16'h0800, 5, 40'h7FFFFFFFFF, 1'b1, 32'hFFFF_FFFF, 16'h0805, 1'b0, 5};
    mem[16'h0605] = 8'h01;
    for (int i = 0; i < 11; i++) begin
      load(v[i].a, v[i].len, v[i].bytes);
      run_decode(v[i].a, v[i].sm, d, ao, e, lat, rds);
      n_checks++; if (d !== v[i].d) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, d, v[i].d); end
      n_checks++; if (ao !== v[i].ao) begin n_fail++; $display("FAIL dir%0d_addr_out: got %h want %h", i, ao, v[i].ao); end
      n_checks++; if (e !== v[i].e) begin n_fail++; $display("FAIL dir%0d_err: got %b want %b", i, e, v[i].e); end
      n_checks++; if (lat != 2 * v[i].n + 1) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, 2 * v[i].n + 1); end
      n_checks++; if (rds != v[i].n) begin n_fail++; $display("FAIL dir%0d_reads: got %0d want %0d", i, rds, v[i].n); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, eao, ao;
    logic [31:0] ed, d;
    logic [7:0]  b;
    bit          sm, ee, e;
    int          len, en, lat, rds;
    for (int it = 0; it < 40; it++) begin
      a   = 16'($urandom);
      sm  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      for (int i = 0; i < 5 && i < len; i++) begin
        b    = 8'($urandom);
        b[7] = (i < len - 1);
        mem[16'(a + i)] = b;
      end
      model(a, sm, ed, eao, ee, en);
      run_decode(a, sm, d, ao, e, lat, rds);
      n_checks++; if (d !== ed) begin n_fail++; $display("FAIL rnd%0d_data: got %h want %h", it, d, ed); end
      n_checks++; if (ao !== eao) begin n_fail++; $display("FAIL rnd%0d_addr_out: got %h want %h", it, ao, eao); end
      n_checks++; if (e !== ee) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", it, e, ee); end
      n_checks++; if (lat != 2 * en + 1) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, 2 * en + 1); end
      n_checks++; if (rds != en) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d want %0d", it, rds, en); end
    end
  endtask

  task automatic test_busy_ignore();
    int base, lat;
    load(16'h0900, 3, 40'h268EE5);
    load(16'h0A00, 1, 40'h05);
    @(negedge clk);
    if (bus.done) @(negedge clk);
    bus.start = 1'b1; bus.addr = 16'h0900; bus.signed_mode = 1'b0;
    base = rd_count;
    @(posedge clk); #1; bus.start = 1'b0; lat = 1;
    @(posedge clk); #1; lat = 2;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b want 1", bus.busy); end
    bus.start = 1'b1; bus.addr = 16'h0A00;
    @(posedge clk); #1; bus.start = 1'b0; lat = 3;
    while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (bus.data !== 32'h0009_8765) begin n_fail++; $display("FAIL busy_data: got %h want 00098765", bus.data); end
    n_checks++; if (bus.addr_out !== 16'h0903) begin n_fail++; $display("FAIL busy_addr_out: got %h want 0903", bus.addr_out); end
    n_checks++; if (lat != 7) begin n_fail++; $display("FAIL busy_latency: got %0d want 7", lat); end
    n_checks++; if (rd_count - base != 3) begin n_fail++; $display("FAIL busy_reads: got %0d want 3", rd_count - base); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [15:0] ao;
    bit          e;
    int          lat, rds;
    load(16'h0B00, 1, 40'h05);
    load(16'h0C00, 2, 40'h0181);
    run_decode(16'h0B00, 1'b0, d, ao, e, lat, rds);
    n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL b2b_first_data: got %h want 00000005", d); end
    bus.start = 1'b1; bus.addr = 16'h0C00; bus.signed_mode = 1'b0;
    @(posedge clk); #1; lat = 1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: busy got %b want 0", bus.busy); end
    @(posedge clk); #1; lat = 2; bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy); end
    while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    n_checks++; if (bus.data !== 32'h81) begin n_fail++; $display("FAIL b2b_data: got %h want 00000081", bus.data); end
    n_checks++; if (bus.addr_out !== 16'h0C02) begin n_fail++; $display("FAIL b2b_addr_out: got %h want 0c02", bus.addr_out); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [15:0] ao;
    bit          e;
    int          lat, rds;
    load(16'h0D00, 3, 40'h268EE5);
    @(negedge clk);
    if (bus.done) @(negedge clk);
    bus.start = 1'b1; bus.addr = 16'h0D00; bus.signed_mode = 1'b0;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_rd: got %b want 0", bus.mem_rd); end
    n_checks++; if (bus.data !== 32'd0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", bus.data); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    reset = 1'b1;
    run_decode(16'h0D00, 1'b0, d, ao, e, lat, rds);
    n_checks++; if (d !== 32'h0009_8765) begin n_fail++; $display("FAIL rstmid_redo_data: got %h want 00098765", d); end
    n_checks++; if (ao !== 16'h0D03) begin n_fail++; $display("FAIL rstmid_redo_addr_out: got %h want 0d03", ao); end
    n_checks++; if (lat != 7) begin n_fail++; $display("FAIL rstmid_redo_latency: got %0d want 7", lat); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vluint_decoder.md
Name: vluint_decoder

Overview:
- Parametrised, fully synchronous variable-length integer (LEB128-style, 7 data bits + continuation bit per byte) decoder for the instruction-fetch path.
- Reads bytes from a single-port synchronous RAM through an explicit read port, then returns the decoded value and the address following the encoding.
- Successor to the fixed-width unsigned decoder. Adds configurable output width, a byte-count limit, a signed (sign-extend) mode, overflow/error reporting, and a clean start/busy/done handshake on one clock.

Parameters:
- ADDR_W, 16, memory address width (set to MEM_ADDR_WIDTH at instantiation).
- OUT_W, 32, decoded value width (set to INSTR_WIDTH); legal range 8..64.
- MAX_BYTES, (OUT_W+6)/7, maximum encoded bytes accepted; 5 at OUT_W=32.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin decode; sampled only in IDLE.
- addr  in  ADDR_W  address of first encoded byte; sampled with start.
- signed_mode  in  1  0 = unsigned, 1 = signed (sign-extend from final byte bit 6); sampled with start.
- busy  out  1  high from the cycle after start accepted until done.
- done  out  1  one-cycle pulse; data, addr_out and err valid that cycle and held until next start.
- data  out  OUT_W  decoded value.
- addr_out  out  ADDR_W  address of the byte after the last byte consumed.
- err  out  1  overflow/over-length flag, valid with done.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd  out  1  RAM read strobe; rdata valid exactly one cycle later.
- mem_rdata  in  8  RAM read data.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State returns to IDLE, including mid-decode. Any in-flight RAM read is discarded.
  - busy=0, done=0, err=0, mem_rd=0, data=0, addr_out=0, mem_addr=0.
- States:
  - IDLE: start=1 latches addr into cur_addr and signed_mode, clears accumulator, shift and byte count k; go to FETCH.
  - FETCH: mem_rd=1, mem_addr=cur_addr for exactly one cycle; go to WAIT.
  - WAIT: sample mem_rdata, OR mem_rdata[6:0] into the accumulator at bit 7k (bits at positions >= OUT_W dropped), cur_addr += 1 (wraps mod 2^ADDR_W).
    - If bit7=1 and k+1 < MAX_BYTES: k += 1; go to FETCH.
    - If bit7=1 and k+1 = MAX_BYTES: set err; go to DONE without further reads.
    - If bit7=0: go to DONE.
  - DONE: done=1 for one cycle with outputs registered; go to IDLE.
- Timing: start accepted at cycle T, N bytes → mem_rd at T+1, T+3, …, T+2N−1; done at T+2N+1. Throughput is 2 cycles/byte. A new start is accepted in the cycle after done.
- start while busy or in DONE: ignored, no queuing.
- Signed mode: on the final byte, if bit6=1 and 7(k+1) < OUT_W, bits [OUT_W−1:7(k+1)] of data are set to 1.
- Overflow, unsigned mode: any dropped payload bit equal to 1 sets err.
- Overflow, signed mode: any dropped payload bit that differs from the final data[OUT_W−1] sets err.
- On err:
  - data holds the truncated value.
  - addr_out = address after the last byte read.
  - done still pulses.
- mem_rd is never asserted outside FETCH. At most one outstanding read.

Test Plan:
- Unsigned single byte: mem[0x0010]=0x05, start addr=0x0010 at T → done at T+3, data=0x00000005, addr_out=0x0011, err=0, exactly one mem_rd.
- Unsigned multi-byte: bytes E5 8E 26 at 0x0100 → data=624485 (0x00098765), addr_out=0x0103, done at T+7, three mem_rd pulses.
- Signed mode:
  - single byte 0x7F → data=0xFFFFFFFF;
  - bytes C0 BB 78 → data=0xFFFE1DC0 (−123456);
  - same bytes with signed_mode=0 → 0x001E1DC0.
- Overflow:
  - FF FF FF FF 0F → 0xFFFFFFFF, err=0;
  - FF FF FF FF 1F → err=1;
  - FF FF FF FF FF → err=1 after exactly 5 reads, addr_out=start+5.
- Wrap and handshake:
  - bytes 81 01 at 0xFFFF/0x0000 → data=0x81, addr_out=0x0001;
  - start pulsed while busy → ignored, no result change.
- Reset mid-decode: reset=0 during second WAIT → next cycle busy=0, mem_rd=0, data=0. A fresh start then decodes correctly.
